// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words and streams them to instruction memory.
// Optional `ENC_RANGE_CHECK_EN: reject bundles whose immediates do not fit their encoding.
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | accepting bundles, writing words
//   DONE   | one-cycle completion pulse
module instr_encoder #(
    parameter int ADDR_W     = 10,
    parameter int BASE_WADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        fmt,
    input  logic [9:0]        aluCtrl,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [31:0]       imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_WADDR);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_remaining;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_mem_we;
    logic              r_err;

    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_word;
    logic        w_fmt_ok;
    logic        w_range_ok;
    logic        w_legal;
    logic        w_accept;
    logic        w_wr_done;

    assign w_f7 = aluCtrl[9:3];
    assign w_f3 = aluCtrl[2:0];

    always_comb begin
        w_word   = '0;
        w_fmt_ok = 1'b1;
        case (fmt)
            4'd0: w_word = {w_f7, rs2, rs1, w_f3, rd, 7'b0110011};
            4'd1: begin
                // shift-immediates carry funct7 in the upper bits, shamt below
                if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    w_word = {w_f7, imm[4:0], rs1, w_f3, rd, 7'b0010011};
                else
                    w_word = {imm[11:0], rs1, w_f3, rd, 7'b0010011};
            end
            4'd2: w_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            4'd3: w_word = {imm[11:5], rs2, rs1, w_f3, imm[4:0], 7'b0100011};
            4'd4: w_word = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11], 7'b1100011};
            4'd5: w_word = {imm[31:12], rd, 7'b0110111};
            4'd6: w_word = {imm[31:12], rd, 7'b0010111};
            4'd7: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            4'd8: w_word = {imm[11:0], rs1, w_f3, rd, 7'b0000011};
            default: w_fmt_ok = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    function automatic logic sfit(input logic [31:0] v, input int n);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (n - 1));
        return (hi == '0) || (hi == '1);
    endfunction

    always_comb begin
        w_range_ok = 1'b1;
        case (fmt)
            4'd1, 4'd2, 4'd3, 4'd8: w_range_ok = sfit(imm, 12);
            4'd4:                   w_range_ok = sfit(imm, 13) && !imm[0];
            4'd7:                   w_range_ok = sfit(imm, 21) && !imm[0];
            4'd5, 4'd6:             w_range_ok = (imm[11:0] == 12'd0);
            default:                w_range_ok = 1'b1;
        endcase
    end
`else
    assign w_range_ok = 1'b1;
`endif

    assign w_legal   = w_fmt_ok && w_range_ok;
    assign in_ready  = (r_state == S_RUN) && (r_remaining != '0) && (!r_mem_we || mem_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_wr_done = r_mem_we && mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_mem_addr  <= BASE;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err       <= 1'b0;
                        r_mem_addr  <= BASE;
                        r_remaining <= prog_len;
                        r_state     <= (prog_len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_wr_done) begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    end
                    // a new word overrides the clear above for back-to-back writes
                    if (w_accept && w_legal) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_word;
                        r_remaining <= r_remaining - ADDR_W'(1);
                    end
                    if (w_accept && !w_legal)
                        r_err <= 1'b1;
                    if (r_remaining == '0 && !r_mem_we)
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: default instance plus a 2-bit-address instance based at word 3.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  prog_len;
    logic        in_valid;
    logic [3:0]  fmt;
    logic [9:0]  aluCtrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        mem_ready;

    logic        in_ready0, mem_we0, busy0, done0, err0;
    logic [9:0]  mem_addr0;
    logic [31:0] mem_wdata0;
    logic        in_ready1, mem_we1, busy1, done1, err1;
    logic [1:0]  mem_addr1;
    logic [31:0] mem_wdata1;

    int total = 0;
    int bad   = 0;
    int nwr   = 0;
    logic [31:0] qd0[$], qd1[$];
    int          qa0[$], qa1[$];
    int          ea0, ea1;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .prog_len(prog_len),
        .in_valid(in_valid), .in_ready(in_ready0), .fmt(fmt), .aluCtrl(aluCtrl),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .mem_we(mem_we0),
        .mem_ready(mem_ready), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .busy(busy0), .done(done0), .err(err0)
    );

    instr_encoder #(.ADDR_W(2), .BASE_WADDR(3)) u_wrap (
        .clk(clk), .reset_n(reset_n), .start(start), .prog_len(prog_len[1:0]),
        .in_valid(in_valid), .in_ready(in_ready1), .fmt(fmt), .aluCtrl(aluCtrl),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .mem_we(mem_we1),
        .mem_ready(mem_ready), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .busy(busy1), .done(done1), .err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        qd0.push_back(w); qa0.push_back(ea0); ea0 = (ea0 + 1) % 1024;
        qd1.push_back(w); qa1.push_back(ea1); ea1 = (ea1 + 1) % 4;
    endtask

    // monitor: every completed write is matched against the scoreboard
    always @(negedge clk) begin
        if (mem_we0 && mem_ready) begin
            nwr++;
            if (qd0.size() == 0) chk("unexpected_write0", 32'd1, 32'd0);
            else begin
                chk("wdata0", mem_wdata0, qd0.pop_front());
                chk("waddr0", 32'(mem_addr0), 32'(qa0.pop_front()));
            end
        end
        if (mem_we1 && mem_ready) begin
            if (qd1.size() == 0) chk("unexpected_write1", 32'd1, 32'd0);
            else begin
                chk("wdata1", mem_wdata1, qd1.pop_front());
                chk("waddr1", 32'(mem_addr1), 32'(qa1.pop_front()));
            end
        end
    end

    // all tasks start and end just after a rising edge
    task automatic do_start(input int len);
        prog_len = 10'(len);
        start    = 1'b1;
        ea0 = 0; ea1 = 3;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic drive(input int f, input int f7, input int f3, input int d,
                         input int s1, input int s2, input logic [31:0] im);
        fmt = 4'(f); aluCtrl = {7'(f7), 3'(f3)}; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = im;
        in_valid = 1'b1;
    endtask

    task automatic send(input int f, input int f7, input int f3, input int d,
                        input int s1, input int s2, input logic [31:0] im);
        int n = 0;
        drive(f, f7, f3, d, s1, s2, im);
        @(negedge clk);
        while (!in_ready0 && n < 100) begin @(negedge clk); n++; end
        if (!in_ready0) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done0 && n < 200) begin @(negedge clk); n++; end
        chk("done_seen", 32'(done0), 32'd1);
        chk("done_seen_wrap", 32'(done1), 32'd1);
        @(negedge clk);
        chk("done_width", 32'(done0), 32'd0);
        chk("busy_after_done", 32'(busy0), 32'd0);
        @(posedge clk); #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready0), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we0), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr0), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata0, 32'd0);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_err"}, 32'(err0), 32'd0);
        chk({tag, "_wrap_addr"}, 32'(mem_addr1), 32'd3);
        chk({tag, "_wrap_misc"}, {26'd0, in_ready1, mem_we1, busy1, done1, err1, |mem_wdata1}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; prog_len = '0; in_valid = 1'b0;
        fmt = '0; aluCtrl = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
        mem_ready = 1'b1; ea0 = 0; ea1 = 3;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;

        // single R word
        do_start(1);
        @(negedge clk);
        chk("busy_run", 32'(busy0), 32'd1);
        @(posedge clk); #2;
        push(32'h002081B3); send(0, 0, 0, 3, 1, 2, 32'd0);
        wait_done();

        // IMM, B, JAL; wrap instance addresses 3,0,1
        do_start(3);
        push(32'hFFF00293); send(1, 0, 0, 5, 0, 0, 32'hFFFF_FFFF);
        push(32'h00208463); send(4, 0, 0, 0, 1, 2, 32'd8);
        push(32'h001000EF); send(7, 0, 0, 1, 0, 0, 32'h800);
        wait_done();

        // srai, lw with negative offset, jalr ignoring funct3
        do_start(3);
        push(32'h4030D093); send(1, 7'h20, 5, 1, 1, 0, 32'd3);
        push(32'hFFC12283); send(8, 0, 2, 5, 2, 0, 32'hFFFF_FFFC);
        push(32'h00008067); send(2, 0, 3, 0, 1, 0, 32'd0);
        wait_done();

        // LUI under back-pressure, then S back-to-back with release
        do_start(2);
        mem_ready = 1'b0;
        push(32'h12345137); send(5, 0, 0, 2, 0, 0, 32'h12345000);
        push(32'h0020A223); drive(3, 0, 2, 0, 1, 2, 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_we", 32'(mem_we0), 32'd1);
            chk("stall_addr", 32'(mem_addr0), 32'd0);
            chk("stall_wdata", mem_wdata0, 32'h12345137);
            chk("stall_in_ready", 32'(in_ready0), 32'd0);
        end
        @(posedge clk); #2;
        mem_ready = 1'b1;
        send(3, 0, 2, 0, 1, 2, 32'd4);
        wait_done();

        // illegal fmt, then out-of-range IMM
        do_start(1);
        send(12, 0, 0, 1, 1, 1, 32'd0);
        @(negedge clk);
        chk("illegal_fmt_err", 32'(err0), 32'd1);
        chk("illegal_fmt_no_we", 32'(mem_we0), 32'd0);
        @(posedge clk); #2;
`ifdef ENC_RANGE_CHECK_EN
        send(1, 0, 0, 0, 0, 0, 32'd2048);
        @(negedge clk);
        chk("range_no_we", 32'(mem_we0), 32'd0);
        chk("range_busy", 32'(busy0), 32'd1);
        @(posedge clk); #2;
        push(32'h002081B3); send(0, 0, 0, 3, 1, 2, 32'd0);
`else
        push(32'h80000013); send(1, 0, 0, 0, 0, 0, 32'd2048);
`endif
        wait_done();
        chk("err_sticky", 32'(err0), 32'd1);

        // empty program: done with no write, err cleared by start
        begin
            int n0;
            n0 = nwr;
            do_start(0);
            wait_done();
            chk("len0_no_write", 32'(nwr - n0), 32'd0);
            chk("len0_err_cleared", 32'(err0), 32'd0);
        end

        // reset in the middle of a stalled write
        do_start(2);
        mem_ready = 1'b0;
        send(0, 0, 0, 3, 1, 2, 32'd0);
        @(negedge clk);
        chk("pre_reset_we", 32'(mem_we0), 32'd1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrun");
        @(posedge clk); #2;
        mem_ready = 1'b1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", 32'(qd0.size() + qd1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
